// File: rtl/simd_rf_pkg.sv
// rtl/simd_rf_pkg.sv - shared types and helpers for the SIMD FP register file write-back path
package simd_rf_pkg;

    localparam int simd_lanes_gp      = 4;
    localparam int simd_data_width_gp = 33;
    localparam int simd_els_gp        = 32;
    localparam int simd_row_width_gp  = $clog2(simd_els_gp) - 2;

    // A single row-wide write request; the merge and the output stage both speak this type.
    typedef struct packed {
        logic [simd_row_width_gp-1:0]                     row;
        logic [simd_lanes_gp-1:0]                         lane_mask;
        logic [simd_lanes_gp-1:0][simd_data_width_gp-1:0] data;
    } simd_wb_req_s;

    function automatic logic [simd_lanes_gp-1:0] lane_onehot(input logic [1:0] lane);
        lane_onehot       = '0;
        lane_onehot[lane] = 1'b1;
    endfunction

endpackage

// File: rtl/simd_rf_wb_merge.sv
// rtl/simd_rf_wb_merge.sv - combinational row/lane compatibility check and A+B write merge
module simd_rf_wb_merge
    import simd_rf_pkg::*;
(
    input  simd_wb_req_s                   a_req_i,
    input  logic [simd_row_width_gp+1:0]   b_addr_i,
    input  logic [simd_data_width_gp-1:0]  b_data_i,
    output logic                           compatible_o,
    output simd_wb_req_s                   merged_o
);

    logic [1:0]                   b_lane;
    logic [simd_row_width_gp-1:0] b_row;

    assign b_lane = b_addr_i[1:0];
    assign b_row  = b_addr_i[simd_row_width_gp+1:2];

    // Valid qualification is left to the arbiter; this only looks at addresses and masks.
    assign compatible_o = (a_req_i.row == b_row) & ~a_req_i.lane_mask[b_lane];

    always_comb begin
        merged_o                = a_req_i;
        merged_o.lane_mask      = a_req_i.lane_mask | lane_onehot(b_lane);
        merged_o.data[b_lane]   = b_data_i;
    end

endmodule

// File: rtl/simd_rf_wb_arbiter.sv
// rtl/simd_rf_wb_arbiter.sv - shares the register file write port between pipeline write-back and remote loads
module simd_rf_wb_arbiter
    import simd_rf_pkg::*;
#(
    // Request struct widths come from the package; override these together with it.
    parameter int data_width_p   = simd_data_width_gp,
    parameter int els_p          = simd_els_gp,
    parameter int starve_limit_p = 4,
    localparam int row_w_lp      = $clog2(els_p) - 2,
    localparam int addr_w_lp     = $clog2(els_p),
    localparam int cnt_w_lp      = $clog2(starve_limit_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,

    input  logic                            a_v_i,
    output logic                            a_ready_o,
    input  logic [row_w_lp-1:0]             a_row_i,
    input  logic [3:0]                      a_lane_mask_i,
    input  logic [4*data_width_p-1:0]       a_data_i,

    input  logic                            b_v_i,
    output logic                            b_yumi_o,
    input  logic [addr_w_lp-1:0]            b_addr_i,
    input  logic [data_width_p-1:0]         b_data_i,

    output logic [3:0]                      w_v_o,
    output logic [addr_w_lp-1:0]            w_addr_o,
    output logic [4*data_width_p-1:0]       w_data_o,

    output logic [cnt_w_lp-1:0]             starve_cnt_o
);

    simd_wb_req_s          a_req;
    simd_wb_req_s          merged_req;
    simd_wb_req_s          wr_req;
    logic                  compatible;
    logic                  merge_ok;
    logic                  starved;
    logic                  a_grant;
    logic                  b_grant;
    logic                  wr_v;
    logic [cnt_w_lp-1:0]   starve_cnt_r;

    always_comb begin
        a_req           = '0;
        a_req.row       = a_row_i;
        a_req.lane_mask = a_lane_mask_i;
        for (int i = 0; i < 4; i++) begin
            a_req.data[i] = a_data_i[i*data_width_p +: data_width_p];
        end
    end

    simd_rf_wb_merge u_merge (
        .a_req_i      (a_req),
        .b_addr_i     (b_addr_i),
        .b_data_i     (b_data_i),
        .compatible_o (compatible),
        .merged_o     (merged_req)
    );

    assign merge_ok = a_v_i & b_v_i & compatible;
    assign starved  = b_v_i & (starve_cnt_r == cnt_w_lp'(starve_limit_p));

    // Fixed A priority, except a starved B takes the port and a compatible pair shares it.
    always_comb begin
        a_ready_o = 1'b1;
        b_yumi_o  = 1'b0;
        if (starved) begin
            b_yumi_o  = 1'b1;
            a_ready_o = merge_ok;
        end else if (merge_ok) begin
            b_yumi_o  = 1'b1;
        end else begin
            b_yumi_o  = b_v_i & ~a_v_i;
        end
    end

    assign a_grant = a_v_i & a_ready_o;
    assign b_grant = b_yumi_o;
    assign wr_v    = a_grant | b_grant;

    // B-only writes reuse the merged data (B lane placed) but take B's row and a single-lane mask.
    always_comb begin
        wr_req = merged_req;
        if (a_grant && !b_grant) begin
            wr_req = a_req;
        end else if (!a_grant && b_grant) begin
            wr_req.row       = b_addr_i[addr_w_lp-1:2];
            wr_req.lane_mask = lane_onehot(b_addr_i[1:0]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_v_o    <= '0;
            w_addr_o <= '0;
            w_data_o <= '0;
        end else begin
            w_v_o <= wr_v ? wr_req.lane_mask : 4'b0000;
            if (wr_v) begin
                w_addr_o <= {wr_req.row, 2'b00};
                w_data_o <= wr_req.data;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            starve_cnt_r <= '0;
        end else if (b_yumi_o) begin
            starve_cnt_r <= '0;
        end else if (b_v_i && (starve_cnt_r != cnt_w_lp'(starve_limit_p))) begin
            starve_cnt_r <= starve_cnt_r + 1'b1;
        end
    end

    assign starve_cnt_o = starve_cnt_r;

endmodule

// File: tb/tb_simd_rf_wb_arbiter.sv
// tb/tb_simd_rf_wb_arbiter.sv - self-checking bench for the register file write-back arbiter
module tb_simd_rf_wb_arbiter;

    localparam int DW = 33;

    logic                clk_i = 1'b0;
    logic                reset_n_i;
    logic                a_v_i;
    logic                a_ready_o;
    logic [2:0]          a_row_i;
    logic [3:0]          a_lane_mask_i;
    logic [4*DW-1:0]     a_data_i;
    logic                b_v_i;
    logic                b_yumi_o;
    logic [4:0]          b_addr_i;
    logic [DW-1:0]       b_data_i;
    logic [3:0]          w_v_o;
    logic [4:0]          w_addr_o;
    logic [4*DW-1:0]     w_data_o;
    logic [2:0]          starve_cnt_o;

    always #5 clk_i = ~clk_i;

    simd_rf_wb_arbiter #(
        .data_width_p   (DW),
        .els_p          (32),
        .starve_limit_p (4)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .a_v_i         (a_v_i),
        .a_ready_o     (a_ready_o),
        .a_row_i       (a_row_i),
        .a_lane_mask_i (a_lane_mask_i),
        .a_data_i      (a_data_i),
        .b_v_i         (b_v_i),
        .b_yumi_o      (b_yumi_o),
        .b_addr_i      (b_addr_i),
        .b_data_i      (b_data_i),
        .w_v_o         (w_v_o),
        .w_addr_o      (w_addr_o),
        .w_data_o      (w_data_o),
        .starve_cnt_o  (starve_cnt_o)
    );

    typedef struct {
        logic                 a_v;
        logic [2:0]           a_row;
        logic [3:0]           a_mask;
        logic [3:0][DW-1:0]   a_data;
        logic                 b_v;
        logic [4:0]           b_addr;
        logic [DW-1:0]        b_data;
        logic                 exp_ar;
        logic                 exp_by;
        logic [2:0]           exp_cnt;
    } vec_t;

    typedef struct {
        logic [3:0]           v;
        logic [4:0]           addr;
        logic [3:0][DW-1:0]   data;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];
    int   tests = 0;
    int   fails = 0;
    logic [4:0] held_addr = '0;

    task automatic chk(input string name, input logic [4*DW-1:0] act, input logic [4*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][DW-1:0] lanes4(input int base);
        logic [3:0][DW-1:0] r;
        for (int i = 0; i < 4; i++) r[i] = DW'(base + i + 1);
        return r;
    endfunction

    task automatic add(input logic av, input int arow, input int amask, input int abase,
                       input logic bv, input int baddr, input int bdata,
                       input logic ear, input logic eby, input int ecnt);
        vec_t v;
        v.a_v = av;  v.a_row = 3'(arow);  v.a_mask = 4'(amask);  v.a_data = lanes4(abase);
        v.b_v = bv;  v.b_addr = 5'(baddr); v.b_data = DW'(bdata);
        v.exp_ar = ear; v.exp_by = eby; v.exp_cnt = 3'(ecnt);
        vecs.push_back(v);
    endtask

    // Expected register-file write for one cycle, from the inputs and the expected grants.
    function automatic wr_t expect_write(input vec_t v);
        wr_t  e;
        logic ag;
        logic bg;
        logic [2:0] row;
        ag = v.a_v & v.exp_ar;
        bg = v.exp_by;
        e.v    = 4'b0000;
        e.data = v.a_data;
        if (ag) e.v = v.a_mask;
        if (bg) begin
            e.v = e.v | (4'b0001 << v.b_addr[1:0]);
            e.data[v.b_addr[1:0]] = v.b_data;
        end
        row = ag ? v.a_row : v.b_addr[4:2];
        if (ag || bg) held_addr = {row, 2'b00};
        e.addr = held_addr;
        return e;
    endfunction

    task automatic idle_inputs();
        a_v_i = 1'b0; a_row_i = '0; a_lane_mask_i = '0; a_data_i = '0;
        b_v_i = 1'b0; b_addr_i = '0; b_data_i = '0;
    endtask

    initial begin
        reset_n_i = 1'b0;
        idle_inputs();

        //   av arow amask abase bv baddr bdata     ar by cnt
        add(1, 3, 4'b0101,  0, 0,  0, 0,          1, 0, 0);  // A only
        add(1, 2, 4'b0011, 10, 1, 10, 'h1AB,     1, 1, 0);  // merge lane 2
        add(1, 0, 4'b0001, 20, 1,  0, 'h0CC,     1, 0, 1);  // same-lane collision
        add(1, 6, 4'b0000, 30, 0,  0, 0,          1, 0, 1);  // zero mask, counter holds
        add(0, 0, 4'b0000,  0, 1,  7, 'h077,     1, 1, 0);  // B alone
        add(1, 2, 4'b0000, 40, 1,  9, 'h099,     1, 1, 0);  // zero mask merges with B
        add(1, 3, 4'b0000, 50, 1,  9, 'h099,     1, 0, 1);  // zero mask still blocks other row
        for (int i = 0; i < 3; i++)
            add(1, 1, 4'b1111, 60 + i, 1, 20, 'h120, 1, 0, i + 2);
        add(1, 1, 4'b1111, 70, 1, 20, 'h120,     0, 1, 0);  // starved: B wins, A stalls
        for (int i = 0; i < 4; i++)
            add(1, 1, 4'b1111, 80 + i, 1, 20, 'h121, 1, 0, i + 1);
        add(1, 5, 4'b1110, 90, 1, 20, 'h155,     1, 1, 0);  // starved and compatible: both
        for (int i = 0; i < 4; i++)
            add(1, 1, 4'b1111, 100 + i, 1, 20, 'h122, 1, 0, i + 1);
        add(1, 4, 4'b0100, 110, 0, 20, 0,         1, 0, 4);  // saturated, B gone: hold
        add(1, 1, 4'b1111, 120, 1, 20, 'h123,     0, 1, 0);  // B back: starved grant

        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_w_v",    w_v_o, 0);
        chk("reset_w_addr", w_addr_o, 0);
        chk("reset_w_data", w_data_o, 0);
        chk("reset_cnt",    starve_cnt_o, 0);

        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            wr_t e;
            wr_t got;
            a_v_i = vecs[i].a_v; a_row_i = vecs[i].a_row; a_lane_mask_i = vecs[i].a_mask;
            a_data_i = vecs[i].a_data;
            b_v_i = vecs[i].b_v; b_addr_i = vecs[i].b_addr; b_data_i = vecs[i].b_data;
            #2;
            chk($sformatf("v%0d_a_ready", i), a_ready_o, vecs[i].exp_ar);
            chk($sformatf("v%0d_b_yumi", i), b_yumi_o, vecs[i].exp_by);
            sb.push_back(expect_write(vecs[i]));
            @(posedge clk_i);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_w_v", i), w_v_o, e.v);
            chk($sformatf("v%0d_w_addr", i), w_addr_o, e.addr);
            got.data = w_data_o;
            for (int l = 0; l < 4; l++)
                if (e.v[l]) chk($sformatf("v%0d_lane%0d", i, l), got.data[l], e.data[l]);
            chk($sformatf("v%0d_cnt", i), starve_cnt_o, vecs[i].exp_cnt);
        end

        // Asynchronous reset while a write is being presented.
        a_v_i = 1'b1; a_row_i = 3'd3; a_lane_mask_i = 4'b0101; a_data_i = lanes4(200);
        b_v_i = 1'b1; b_addr_i = 5'd0; b_data_i = DW'(5);
        @(posedge clk_i);
        #1;
        chk("pre_rst_w_v", w_v_o, 4'b0101);
        chk("pre_rst_w_addr", w_addr_o, 5'd12);
        chk("pre_rst_cnt", starve_cnt_o, 1);
        idle_inputs();
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_w_v", w_v_o, 0);
        chk("mid_rst_w_addr", w_addr_o, 0);
        chk("mid_rst_w_data", w_data_o, 0);
        chk("mid_rst_cnt", starve_cnt_o, 0);
        @(posedge clk_i);
        #1;
        chk("in_rst_w_v", w_v_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post_rst_w_v", w_v_o, 0);
        chk("post_rst_cnt", starve_cnt_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/simd_rf_wb_arbiter.md
# simd_rf_wb_arbiter

Write-back arbiter and sequencer for the 4-lane SIMD FP register file. It shares the register file's single row-addressed write port between two requesters: the FPU/SIMD pipeline write-back (port A) and the scalar remote-load return (port B). When both target the same row on disjoint lanes, it merges them into one write. It drives the register file's lane-enable, row-address and lane-data inputs from a registered output stage, and bounds port B starvation with a counter.

## Interface
Parameters:
- data_width_p, 33, lane data width (recoded FP); must equal the register file's width_p.
- els_p, 32, register count; multiple of 4; row count is els_p/4.
- starve_limit_p, 4, number of consecutive denied cycles after which port B wins; must be ≥1.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- a_v_i  in  1  port A write-back valid.
- a_ready_o  out  1  port A accepted this cycle (transfer = a_v_i & a_ready_o).
- a_row_i  in  clog2(els_p)-2  target row.
- a_lane_mask_i  in  4  lanes to write; bit i ↔ lane i.
- a_data_i  in  4×data_width_p  per-lane data.
- b_v_i  in  1  port B (remote load) valid.
- b_yumi_o  out  1  port B consumed this cycle.
- b_addr_i  in  clog2(els_p)  full register address; [1:0] = lane, upper bits = row.
- b_data_i  in  data_width_p  load data.
- w_v_o  out  4  one-hot-or-multi lane write enables to the register file.
- w_addr_o  out  clog2(els_p)  write address; [1:0] driven 0, upper bits = row.
- w_data_o  out  4×data_width_p  lane write data.
- starve_cnt_o  out  clog2(starve_limit_p+1)  current port B denial count (debug/perf).

## Operation
- Arbitration per cycle, fixed priority A > B, with the following overrides:
  - Merge: if a_v_i & b_v_i, a_row_i == b_addr_i row bits, and a_lane_mask_i bit b_addr_i[1:0] == 0, both are granted; the combined mask = a_lane_mask_i | onehot(b lane).
  - Starvation: if starve_cnt == starve_limit_p and b_v_i, B is granted. A is granted only if merge-compatible; otherwise a_ready_o = 0.
  - Otherwise: a_ready_o = 1 (A always ready when not overridden); b_yumi_o = b_v_i & ~a_v_i.
- Lane expansion: B data is placed in lane b_addr_i[1:0]; other lanes take A data (merge) or are don't-care with the enable low.
- A with a_lane_mask_i == 0 is accepted (a_ready_o = 1) and produces w_v_o = 0. It still counts as an A grant that blocks a non-mergeable B (the row comparison still applies).
- Starvation counter:
  - cleared on any b_yumi_o;
  - increments when b_v_i & ~b_yumi_o, saturating at starve_limit_p;
  - holds when ~b_v_i.
- Output stage: on each posedge, w_v_o/w_addr_o/w_data_o capture the granted write. With no grant, w_v_o = 0 and addr/data hold their previous value.

## Timing
- Grant is combinational in cycle k. The write appears on w_* in cycle k+1 and lands in the register file at the end of cycle k+1.
- Throughput is one register-file write per cycle; a merged grant retires 2 requests per cycle.
- Reset (asynchronous assert, synchronous-release assumption): w_v_o = 0, w_addr_o = 0, w_data_o = 0, starve_cnt = 0. a_ready_o and b_yumi_o are combinational and follow the rules above from the first cycle after release.
- Reset mid-operation: a write captured but not yet presented is dropped; requesters must re-issue.
- b_yumi_o never asserts without b_v_i. a_ready_o may assert without a_v_i.
- Simultaneous A and B to the same row and same lane, not starved: A wins and B waits; the counter increments.
- Counter at saturation with B deasserting: the counter holds; priority returns to A until B reasserts.

## Structure
- Package simd_rf_pkg:
  - simd_lanes_gp = 4;
  - typedef simd_wb_req_s {row, lane_mask[3:0], data[3:0]};
  - function lane_onehot(lane).
- One sub-module, simd_rf_wb_merge: purely combinational compatibility check plus mask/data merge. Takes the A request and the B address/data; returns a compatible flag and the merged simd_wb_req_s.
- The top level holds the arbitration, the starvation counter and the output register.

## Test plan
- A only: row 3, mask 4'b0101, data {4,3,2,1} at cycle 0 → cycle 1 w_v_o = 4'b0101, w_addr_o = 5'd12, lanes 0/2 = 1/3.
- Merge: A row 2, mask 4'b0011 with B addr 5'd10, same cycle → a_ready_o = b_yumi_o = 1; next cycle w_v_o = 4'b0111, lane 2 = B data.
- Conflict: A row 1 every cycle, B addr 5'd20 held, starve_limit_p = 4 → b_yumi_o low for 4 cycles, high in cycle 4 with a_ready_o = 0, starve_cnt_o back to 0 after.
- Same-lane collision: A row 0 mask 4'b0001 and B addr 5'd0 → A granted, B denied, starve_cnt_o = 1.
- Zero mask: A valid with mask 0 → a_ready_o = 1, next cycle w_v_o = 0.
- Reset mid-stream: reset_n_i low while w_v_o ≠ 0 → w_v_o, w_addr_o, starve_cnt_o = 0 immediately; no register-file write.
